// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and size decode for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE0,
      ST_WAIT0,
      ST_ISSUE1,
      ST_WAIT1,
      ST_DONE
   } lsu_state_e;

   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      if (we)
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / data placement across two
// words, and load merge with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be0,
   output logic [3:0]  st_be1,
   output logic        st_split,
   output logic [31:0] st_wdata0,
   output logic [31:0] st_wdata1,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word0,
   input  logic [31:0] ld_word1,
   output logic [31:0] ld_rdata
);

   logic [7:0]  base_mask;
   logic [7:0]  mask;
   logic [63:0] lanes;
   logic [31:0] merged;

   always_comb begin
      case (size_bytes(st_funct3))
         3'd1:    base_mask = 8'h01;
         3'd2:    base_mask = 8'h03;
         default: base_mask = 8'h0f;
      endcase
      mask  = base_mask << st_off;
      lanes = {32'b0, st_wdata} << {st_off, 3'b000};
   end

   assign st_be0    = mask[3:0];
   assign st_be1    = mask[7:4];
   assign st_split  = |mask[7:4];
   assign st_wdata0 = lanes[31:0];
   assign st_wdata1 = lanes[63:32];

   always_comb begin
      merged = 32'({ld_word1, ld_word0} >> {ld_off, 3'b000});
      case (ld_funct3)
         F3_B:    ld_rdata = {{24{merged[7]}}, merged[7:0]};
         F3_H:    ld_rdata = {{16{merged[15]}}, merged[15:0]};
         F3_BU:   ld_rdata = {24'b0, merged[7:0]};
         F3_HU:   ld_rdata = {16'b0, merged[15:0]};
         default: ld_rdata = merged;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator: word-aligned memory transactions with byte
// enables, splitting boundary-crossing accesses into two transactions.
//
// state  | meaning
// IDLE   | ready for a request
// ISSUE0 | first (or only) word transaction requested, waiting for grant
// WAIT0  | first word read granted, waiting for read data
// ISSUE1 | second word of a split access requested, waiting for grant
// WAIT1  | second word read granted, waiting for read data
// DONE   | one-cycle response pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr0_q, addr0_d;
   logic [3:0]  be0_q, be0_d;
   logic [3:0]  be1_q, be1_d;
   logic [31:0] wdata0_q, wdata0_d;
   logic [31:0] wdata1_q, wdata1_d;
   logic        split_q, split_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [3:0]  st_be0, st_be1;
   logic        st_split;
   logic [31:0] st_wdata0, st_wdata1;
   logic [31:0] ld_word0;
   logic [31:0] ld_rdata;

   // In WAIT0 the first word is still on the bus; afterwards it comes from rdata0_q.
   assign ld_word0 = (state_q == ST_WAIT0) ? mem_rdata : rdata0_q;

   lsu_align u_align (
      .st_funct3 (req_funct3),
      .st_off    (req_addr[1:0]),
      .st_wdata  (req_wdata),
      .st_be0    (st_be0),
      .st_be1    (st_be1),
      .st_split  (st_split),
      .st_wdata0 (st_wdata0),
      .st_wdata1 (st_wdata1),
      .ld_funct3 (funct3_q),
      .ld_off    (off_q),
      .ld_word0  (ld_word0),
      .ld_word1  (mem_rdata),
      .ld_rdata  (ld_rdata)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      addr0_d      = addr0_q;
      be0_d        = be0_q;
      be1_d        = be1_q;
      wdata0_d     = wdata0_q;
      wdata1_d     = wdata1_q;
      split_d      = split_q;
      rdata0_d     = rdata0_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 32'h0;
      mem_be       = 4'h0;
      mem_wdata    = 32'h0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               addr0_d  = {req_addr[31:2], 2'b00};
               be0_d    = st_be0;
               be1_d    = st_be1;
               wdata0_d = st_wdata0;
               wdata1_d = st_wdata1;
               split_d  = st_split;
               if (funct3_legal(req_we, req_funct3)) begin
                  state_d = ST_ISSUE0;
               end else begin
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_ISSUE0: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr0_q;
            mem_be    = be0_q;
            mem_wdata = wdata0_q;
            if (mem_gnt) begin
               if (!we_q) begin
                  state_d = ST_WAIT0;
               end else if (split_q) begin
                  state_d = ST_ISSUE1;
               end else begin
                  resp_err_d   = 1'b0;
                  resp_rdata_d = 32'h0;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_WAIT0: begin
            if (mem_rvalid) begin
               rdata0_d = mem_rdata;
               if (split_q) begin
                  state_d = ST_ISSUE1;
               end else begin
                  resp_err_d   = 1'b0;
                  resp_rdata_d = ld_rdata;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_ISSUE1: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr0_q + 32'd4;
            mem_be    = be1_q;
            mem_wdata = wdata1_q;
            if (mem_gnt) begin
               if (we_q) begin
                  resp_err_d   = 1'b0;
                  resp_rdata_d = 32'h0;
                  state_d      = ST_DONE;
               end else begin
                  state_d = ST_WAIT1;
               end
            end
         end
         ST_WAIT1: begin
            if (mem_rvalid) begin
               resp_err_d   = 1'b0;
               resp_rdata_d = ld_rdata;
               state_d      = ST_DONE;
            end
         end
         ST_DONE: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         addr0_q      <= 32'h0;
         be0_q        <= 4'h0;
         be1_q        <= 4'h0;
         wdata0_q     <= 32'h0;
         wdata1_q     <= 32'h0;
         split_q      <= 1'b0;
         rdata0_q     <= 32'h0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         addr0_q      <= addr0_d;
         be0_q        <= be0_d;
         be1_q        <= be1_d;
         wdata0_q     <= wdata0_d;
         wdata1_q     <= wdata1_d;
         split_q      <= split_d;
         rdata0_q     <= rdata0_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
